// File: rtl/jt1943_obj_pkg.sv
// Shared definitions for the 1943 object-bus arbiter.
// Contents: arbiter state encoding, default BA wait limit, state decode helpers.
package jt1943_obj_pkg;

    // Default BA wait limit in cen6 ticks
    localparam int unsigned TOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HALT    = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // CPU is held off in every state except IDLE
    function automatic logic st_halts(arb_state_t s);
        return s != ST_IDLE;
    endfunction

    function automatic logic st_grants(arb_state_t s);
        return s == ST_GRANT;
    endfunction

endpackage

// File: rtl/jt1943_okstretch.sv
// OKOUT stretcher: a one-clk cpu write pulse becomes a level that lasts until
// the first cen6 tick after it was set. A set on the clearing tick wins.
// Ports: clk, rst_n (async, active-low), cen6 (clock enable),
//        set (one-clk pulse), okout (registered strobe).
module jt1943_okstretch (
    input  logic clk,
    input  logic rst_n,
    input  logic cen6,
    input  logic set,
    output logic okout
);

    // Set has priority over the cen6 clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    okout <= 1'b0;
        else if (set)  okout <= 1'b1;
        else if (cen6) okout <= 1'b0;
    end

endmodule

// File: rtl/jt1943_busarb.sv
// Object-bus arbiter between the main CPU and the sprite DMA for the shared RAM.
// Ports: clk, rst_n (async, active-low), cen6 (6 MHz enable);
//        DMA side: bus_req, bus_ack, blen, AB, DB, OKOUT;
//        CPU side: cpu_AB, cpu_dout, cpu_wr, cpu_ok, cpu_ba, cpu_halt;
//        RAM side: ram_addr, ram_din, ram_we, ram_dout; arb_err (sticky timeout).
// Optional feature: define BUSARB_TIMEOUT_EN to abandon a HALT that never sees
// cpu_ba within TOUT cen6 ticks; otherwise HALT waits forever and arb_err is 0.
module jt1943_busarb
    import jt1943_obj_pkg::*;
#(
    parameter int unsigned AW   = 13,
    parameter int unsigned TOUT = TOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen6,
    input  logic          bus_req,
    output logic          bus_ack,
    input  logic          blen,
    input  logic [AW-1:0] AB,
    output logic [7:0]    DB,
    output logic          OKOUT,
    input  logic [AW-1:0] cpu_AB,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_wr,
    input  logic          cpu_ok,
    input  logic          cpu_ba,
    output logic          cpu_halt,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    output logic          arb_err
);

    arb_state_t    state, state_nxt;
    logic          halt_nxt, ack_nxt;
    logic          timeout_c;
    logic          lock_c;
    logic [AW-1:0] addr_hold;

`ifdef BUSARB_TIMEOUT_EN
    localparam int unsigned CW = (TOUT > 1) ? $clog2(TOUT) : 1;

    logic [CW-1:0] to_cnt;
    logic          lock;
    logic          err;

    // Fires on the TOUT-th cen6 tick spent in HALT without BA
    assign timeout_c = cen6 && (state == ST_HALT) && bus_req && !cpu_ba
                       && (to_cnt == CW'(TOUT - 1));
    assign lock_c    = lock;
    assign arb_err   = err;

    // HALT tick counter, restarts whenever HALT is left or entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (cen6) begin
            if (state == ST_HALT && state_nxt == ST_HALT) to_cnt <= to_cnt + CW'(1);
            else                                          to_cnt <= '0;
        end
    end

    // After a timeout, block new requests until the DMA drops bus_req
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (timeout_c) begin
                lock <= 1'b1;
                err  <= 1'b1;
            end else if (cen6 && state == ST_IDLE && !bus_req) begin
                lock <= 1'b0;
            end
        end
    end
`else
    logic unused_tout;

    assign timeout_c   = 1'b0;
    assign lock_c      = 1'b0;
    assign arb_err     = 1'b0;
    assign unused_tout = (TOUT == 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic, advancing only on cen6
    always_comb begin
        state_nxt = state;
        if (cen6) begin
            case (state)
                ST_IDLE:    if (bus_req && !lock_c) state_nxt = ST_HALT;
                ST_HALT: begin
                    if (!bus_req)      state_nxt = ST_IDLE;
                    else if (cpu_ba)   state_nxt = ST_GRANT;
                    else if (timeout_c) state_nxt = ST_IDLE;
                end
                ST_GRANT:   if (!bus_req) state_nxt = ST_RELEASE;
                ST_RELEASE: state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state so outputs change on the same tick
    always_comb begin
        halt_nxt = 1'b0;
        ack_nxt  = 1'b0;
        halt_nxt = st_halts(state_nxt);
        ack_nxt  = st_grants(state_nxt);
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_halt <= 1'b0;
            bus_ack  <= 1'b0;
        end else begin
            cpu_halt <= halt_nxt;
            bus_ack  <= ack_nxt;
        end
    end

    // Last address presented to the RAM, reused while DMA has blen low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_hold <= '0;
        else        addr_hold <= ram_addr;
    end

    // RAM port mux; CPU writes are dropped while DMA owns the bus
    always_comb begin
        ram_addr = cpu_AB;
        ram_din  = cpu_dout;
        ram_we   = cpu_wr && rst_n;
        if (state == ST_GRANT) begin
            ram_addr = blen ? AB : addr_hold;
            ram_we   = 1'b0;
        end
    end

    assign DB = ram_dout;

    jt1943_okstretch u_okstretch (
        .clk   (clk),
        .rst_n (rst_n),
        .cen6  (cen6),
        .set   (cpu_ok),
        .okout (OKOUT)
    );

endmodule
